// File: rtl/clock_divider_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clock_divider_pkg;

   // System clock frequency in Hz.
   localparam int unsigned CLK_FREQ = 12_000_000;

   // Half-period in clk cycles for an output frequency of hz.
   function automatic int unsigned hz_to_half(input int unsigned hz);
      return CLK_FREQ / hz / 2;
   endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: half-period counter, active and shadow half-period,
// pending flag, divided clock and rising-edge pulse.
module clock_divider_channel
   import clock_divider_pkg::*;
#(
   parameter int unsigned CNT_W        = 24,
   parameter int unsigned DEFAULT_HALF = 6_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             resync,
   input  logic             load,
   input  logic [CNT_W-1:0] load_half,
   output logic             div_clk,
   output logic             div_pulse,
   output logic             pending
);

   localparam logic [CNT_W-1:0] RST_HALF = DEFAULT_HALF[CNT_W-1:0];

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] half;
   logic [CNT_W-1:0] shadow;
   logic [CNT_W-1:0] last;
   logic             wrap;

   // Terminal count; a half-period of 0 behaves like 1 (toggle every cycle).
   always_comb begin
      last = (half == '0) ? '0 : half - CNT_W'(1);
      wrap = (cnt == last);
   end

   // Counter, half-period update and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         half      <= RST_HALF;
         shadow    <= RST_HALF;
         pending   <= 1'b0;
         div_clk   <= 1'b0;
         div_pulse <= 1'b0;
      end else if (resync) begin
         cnt       <= '0;
         div_clk   <= 1'b0;
         div_pulse <= 1'b0;
         pending   <= 1'b0;
         // A load coinciding with resync takes effect at once.
         if (load) begin
            half   <= load_half;
            shadow <= load_half;
         end else if (pending) begin
            half <= shadow;
         end
      end else begin
         div_pulse <= 1'b0;
         if (!enable) begin
            // Idle channel: apply a waiting value now, keep div_clk level.
            if (pending) begin
               half    <= shadow;
               cnt     <= '0;
               pending <= 1'b0;
            end
         end else if (wrap) begin
            cnt       <= '0;
            div_clk   <= ~div_clk;
            div_pulse <= ~div_clk;
            // Swap only at the falling wrap so the running period completes.
            if (div_clk && pending) begin
               half    <= shadow;
               pending <= 1'b0;
            end
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         // A new load lands after any apply above, so it stays pending.
         if (load) begin
            shadow  <= load_half;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel clock divider: load decode and resync fan-out to channels.
module clock_divider_multi
   import clock_divider_pkg::*;
#(
   parameter int unsigned CHANNELS     = 4,
   parameter int unsigned CNT_W        = 24,
   parameter int unsigned DEFAULT_HALF = hz_to_half(1),
   localparam int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] enable,
   input  logic                resync,
   input  logic                load,
   input  logic [CH_W-1:0]     load_ch,
   input  logic [CNT_W-1:0]    load_half,
   output logic [CHANNELS-1:0] div_clk,
   output logic [CHANNELS-1:0] div_pulse,
   output logic [CHANNELS-1:0] pending
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      localparam logic [CH_W-1:0] IDX = CH_W'(i);
      logic hit;

      // Out-of-range channel numbers match no channel and are dropped.
      assign hit = load && (load_ch == IDX);

      clock_divider_channel #(
         .CNT_W        (CNT_W),
         .DEFAULT_HALF (DEFAULT_HALF)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .enable    (enable[i]),
         .resync    (resync),
         .load      (hit),
         .load_half (load_half),
         .div_clk   (div_clk[i]),
         .div_pulse (div_pulse[i]),
         .pending   (pending[i])
      );
   end

endmodule
